// File: rtl/data_bus_pkg.sv
// Shared types and default memory map for the core-to-slave data bus router.
// Slice i of the packed region tables belongs to slave i; slave 0 is disabled by default.
package data_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [31:0] DRAM_BASE  = 32'h8000_0000;
    localparam logic [31:0] DRAM_MASK  = 32'hC000_0000;
    localparam logic [31:0] DEV_BASE   = 32'hC000_0000;
    localparam logic [31:0] DEV_MASK   = 32'hF000_0000;
    localparam logic [31:0] CLINT_BASE = 32'hF000_0000;
    localparam logic [31:0] CLINT_MASK = 32'hF000_0000;

    localparam logic [127:0] DEFAULT_REGION_BASE = {CLINT_BASE, DEV_BASE, DRAM_BASE, 32'h0000_0000};
    localparam logic [127:0] DEFAULT_REGION_MASK = {CLINT_MASK, DEV_MASK, DRAM_MASK, 32'h0000_0000};

endpackage

// File: rtl/bus_region_decode.sv
// Combinational address decoder: per-region hit vector plus the index of the
// lowest-numbered hitting region. Regions with an all-zero mask never hit.
module bus_region_decode
    import data_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int IDX_WIDTH  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_BASE = DEFAULT_REGION_BASE,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_MASK = DEFAULT_REGION_MASK
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] hit,
    output logic [IDX_WIDTH-1:0]  hit_idx
);

    always_comb begin
        hit     = '0;
        hit_idx = '0;
        // Walk downward so the lowest matching index is the last one written.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
                ((addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 (REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]))) begin
                hit[i]  = 1'b1;
                hit_idx = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/data_bus_router.sv
// Routes single outstanding core requests to one of NUM_SLAVES slaves by address,
// with decode-miss and timeout error responses.
module data_bus_router
    import data_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_BASE = DEFAULT_REGION_BASE,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_MASK = DEFAULT_REGION_MASK,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           p_strobe,
    input  logic [ADDR_WIDTH-1:0]          p_addr,
    input  logic                           p_rw,
    input  logic [DATA_WIDTH/8-1:0]        p_byte_enable,
    input  logic [DATA_WIDTH-1:0]          p_wdata,
    output logic [DATA_WIDTH-1:0]          p_rdata,
    output logic                           p_ready,
    output logic                           p_error,
    output logic [NUM_SLAVES-1:0]          s_strobe,
    output logic [ADDR_WIDTH-1:0]          s_addr,
    output logic                           s_rw,
    output logic [DATA_WIDTH/8-1:0]        s_byte_enable,
    output logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]          s_ready,
    output state_t                         dbg_state
);

    localparam int IDX_WIDTH = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    state_t                 state;
    logic [IDX_WIDTH-1:0]   sel;
    logic [CNT_WIDTH-1:0]   busy_cnt;
    logic [NUM_SLAVES-1:0]  hit;
    logic [IDX_WIDTH-1:0]   hit_idx;
    logic                   any_hit;
    logic                   sel_ready;
    logic [DATA_WIDTH-1:0]  sel_rdata;
    logic                   timed_out;

    bus_region_decode #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_SLAVES  (NUM_SLAVES),
        .IDX_WIDTH   (IDX_WIDTH),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_decode (
        .addr    (p_addr),
        .hit     (hit),
        .hit_idx (hit_idx)
    );

    assign any_hit   = |hit;
    assign sel_ready = s_ready[sel];
    assign sel_rdata = s_rdata[sel*DATA_WIDTH +: DATA_WIDTH];
    // busy_cnt is 1 in the first BUSY cycle, so it equals the BUSY cycle number.
    assign timed_out = (state == ST_BUSY) && !sel_ready && (busy_cnt == CNT_LIMIT);
    assign dbg_state = state;

    always_comb begin
        p_ready = 1'b0;
        p_error = 1'b0;
        p_rdata = '0;
        case (state)
            ST_BUSY: begin
                if (sel_ready) begin
                    p_ready = 1'b1;
                    p_rdata = sel_rdata;
                end else if (timed_out) begin
                    p_ready = 1'b1;
                    p_error = 1'b1;
                end
            end
            ST_ERR: begin
                p_ready = 1'b1;
                p_error = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            sel           <= '0;
            busy_cnt      <= '0;
            s_strobe      <= '0;
            s_addr        <= '0;
            s_rw          <= 1'b0;
            s_byte_enable <= '0;
            s_wdata       <= '0;
        end else begin
            s_strobe <= '0;
            case (state)
                ST_IDLE: begin
                    if (p_strobe) begin
                        if (any_hit) begin
                            sel           <= hit_idx;
                            s_addr        <= p_addr;
                            s_rw          <= p_rw;
                            s_byte_enable <= p_byte_enable;
                            s_wdata       <= p_wdata;
                            s_strobe      <= NUM_SLAVES'(1) << hit_idx;
                            busy_cnt      <= CNT_WIDTH'(1);
                            state         <= ST_BUSY;
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_BUSY: begin
                    if (sel_ready || timed_out) begin
                        state <= ST_IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + CNT_WIDTH'(1);
                    end
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_router.sv
// Bench for data_bus_router: directed vector table, reset corner sequences and
// randomized transactions checked against an address-map reference model.
module tb_data_bus_router;
    import data_bus_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int BW = DW / 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              p_strobe;
    logic [AW-1:0]     p_addr;
    logic              p_rw;
    logic [BW-1:0]     p_byte_enable;
    logic [DW-1:0]     p_wdata;
    logic [DW-1:0]     p_rdata;
    logic              p_ready;
    logic              p_error;
    logic [NS-1:0]     s_strobe;
    logic [AW-1:0]     s_addr;
    logic              s_rw;
    logic [BW-1:0]     s_byte_enable;
    logic [DW-1:0]     s_wdata;
    logic [NS*DW-1:0]  s_rdata;
    logic [NS-1:0]     s_ready;
    state_t            dbg_state;

    int checks = 0;
    int failures = 0;
    logic [DW:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic [3:0]  exp_strobe;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[9];

    data_bus_router #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .p_strobe      (p_strobe),
        .p_addr        (p_addr),
        .p_rw          (p_rw),
        .p_byte_enable (p_byte_enable),
        .p_wdata       (p_wdata),
        .p_rdata       (p_rdata),
        .p_ready       (p_ready),
        .p_error       (p_error),
        .s_strobe      (s_strobe),
        .s_addr        (s_addr),
        .s_rw          (s_rw),
        .s_byte_enable (s_byte_enable),
        .s_wdata       (s_wdata),
        .s_rdata       (s_rdata),
        .s_ready       (s_ready),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Address map as written in the memory-map table: lowest matching enabled region wins.
    function automatic int ref_slave(input logic [31:0] a);
        logic [31:0] base[4];
        logic [31:0] mask[4];
        base = '{32'h0000_0000, 32'h8000_0000, 32'hC000_0000, 32'hF000_0000};
        mask = '{32'h0000_0000, 32'hC000_0000, 32'hF000_0000, 32'hF000_0000};
        for (int i = 0; i < 4; i++) begin
            if (mask[i] != 0 && (a & mask[i]) == (base[i] & mask[i])) return i;
        end
        return -1;
    endfunction

    function automatic logic [NS*DW-1:0] junk_rdata();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // delay: cycles after the strobe cycle that the selected slave answers (-1 = never).
    task automatic run_txn(input string name, input logic [31:0] addr, input logic rw,
                           input logic [3:0] be, input logic [31:0] wdata, input int delay,
                           input logic [31:0] rdata, input logic [3:0] exp_strobe,
                           input logic exp_err, input logic [31:0] exp_data, input int exp_cyc);
        int sl;
        int resp_cyc;
        int strobe_cycles;
        int ready_cycles;
        logic [3:0] first_strobe;
        logic [DW:0] exp_w;
        sl = -1;
        for (int i = 0; i < NS; i++) if (exp_strobe[i]) sl = i;
        exp_q.push_back({exp_err, exp_data});
        resp_cyc = -1;
        strobe_cycles = 0;
        ready_cycles = 0;
        first_strobe = '0;
        @(negedge clk);
        p_strobe = 1'b1;
        p_addr = addr;
        p_rw = rw;
        p_byte_enable = be;
        p_wdata = wdata;
        s_ready = '0;
        s_rdata = junk_rdata();
        #1;
        check({name, " req_cycle_ready"}, {p_ready, p_rdata}, 0);
        for (int cyc = 1; cyc <= TO + 3; cyc++) begin
            @(negedge clk);
            if (resp_cyc >= 0) p_strobe = 1'b0;
            s_rdata = junk_rdata();
            s_ready = 4'($urandom_range(0, 15)) & ~exp_strobe;
            if (sl >= 0 && cyc - 1 == delay) begin
                s_ready[sl] = 1'b1;
                s_rdata[sl*DW +: DW] = rdata;
            end
            if (sl >= 0 && resp_cyc >= 0) s_ready[sl] = 1'b1;
            #1;
            if (s_strobe != 0) strobe_cycles++;
            if (cyc == 1) begin
                first_strobe = s_strobe;
                if (sl >= 0)
                    check({name, " latched_req"}, {s_addr, s_rw, s_byte_enable, s_wdata}, {addr, rw, be, wdata});
            end
            if (p_ready) begin
                ready_cycles++;
                if (resp_cyc < 0) begin
                    resp_cyc = cyc;
                    exp_w = exp_q.pop_front();
                    check({name, " resp"}, {p_error, p_rdata}, exp_w);
                    if (sl >= 0)
                        check({name, " held_req"}, {s_addr, s_rw, s_byte_enable, s_wdata}, {addr, rw, be, wdata});
                end
            end else begin
                check({name, " rdata_when_idle"}, {p_error, p_rdata}, 0);
            end
        end
        if (resp_cyc < 0) exp_w = exp_q.pop_front();
        check({name, " resp_cycle"}, resp_cyc, exp_cyc);
        check({name, " strobe"}, first_strobe, exp_strobe);
        check({name, " strobe_cycles"}, strobe_cycles, (exp_strobe != 0) ? 1 : 0);
        check({name, " ready_cycles"}, ready_cycles, 1);
        p_strobe = 1'b0;
        s_ready = '0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {p_ready, p_error, p_rdata, s_strobe, s_addr, s_rw, s_byte_enable, s_wdata, dbg_state},
              {1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, ST_IDLE});
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] rd;
        logic [3:0]  es;
        int          dly;
        int          sl;
        rst = 1'b1;
        p_strobe = 1'b0;
        p_addr = '0;
        p_rw = 1'b0;
        p_byte_enable = '0;
        p_wdata = '0;
        s_rdata = '0;
        s_ready = '0;

        vecs[0] = '{32'hC000_0010, 1'b0, 4'hF, 32'h0,         3,  32'hDEAD_BEEF, 4'b0100, 1'b0, 32'hDEAD_BEEF, 4};
        vecs[1] = '{32'h8000_0004, 1'b1, 4'hF, 32'h1234_5678, 2,  32'h0,         4'b0010, 1'b0, 32'h0,         3};
        vecs[2] = '{32'h4000_0000, 1'b0, 4'hF, 32'h0,         0,  32'h0,         4'b0000, 1'b1, 32'h0,         1};
        vecs[3] = '{32'hF000_0000, 1'b0, 4'hF, 32'h0,         -1, 32'h0,         4'b1000, 1'b1, 32'h0,         8};
        vecs[4] = '{32'hBFFF_FFFC, 1'b0, 4'h3, 32'h0,         0,  32'hA5A5_A5A5, 4'b0010, 1'b0, 32'hA5A5_A5A5, 1};
        vecs[5] = '{32'hCFFF_FFF0, 1'b1, 4'h8, 32'hCAFE_0001, 7,  32'h0102_0304, 4'b0100, 1'b0, 32'h0102_0304, 8};
        vecs[6] = '{32'hF123_4567, 1'b0, 4'hF, 32'h0,         8,  32'h5555_AAAA, 4'b1000, 1'b1, 32'h0,         8};
        vecs[7] = '{32'h0000_0000, 1'b1, 4'h1, 32'hFFFF_FFFF, 0,  32'h0,         4'b0000, 1'b1, 32'h0,         1};
        vecs[8] = '{32'h7FFF_FFFF, 1'b0, 4'hF, 32'h0,         1,  32'h0,         4'b0000, 1'b1, 32'h0,         1};

        // Reset and idle behaviour.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        s_ready = 4'hF;
        s_rdata = junk_rdata();
        #1;
        check("idle_s_ready_ignored", {p_ready, p_error, p_rdata}, 0);
        s_ready = '0;

        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rw, vecs[i].be, vecs[i].wdata,
                    vecs[i].delay, vecs[i].rdata, vecs[i].exp_strobe, vecs[i].exp_err,
                    vecs[i].exp_data, vecs[i].exp_cyc);
        end

        // Stray s_ready[0] during a slave 1 transaction, then reset mid-BUSY.
        @(negedge clk);
        p_strobe = 1'b1;
        p_addr = 32'h8000_0100;
        p_rw = 1'b0;
        p_byte_enable = 4'hF;
        s_ready = '0;
        #1;
        check("abort_req_cycle", p_ready, 0);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            s_ready = 4'b0001;
            s_rdata = junk_rdata();
            #1;
            if (cyc == 1) check("abort_strobe", s_strobe, 4'b0010);
            check($sformatf("abort_stray_c%0d", cyc), {p_ready, p_error, p_rdata}, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        p_strobe = 1'b0;
        s_ready = '0;
        #1;
        check("abort_rst_cycle", p_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        s_ready = 4'b0010;
        s_rdata = junk_rdata();
        #1;
        check_all_zero("abort_after_reset");
        @(negedge clk);
        #1;
        check("abort_late_ready_ignored", {p_ready, p_error, p_rdata}, 0);
        s_ready = '0;
        run_txn("after_abort", 32'h8000_0200, 1'b1, 4'h5, 32'h0BAD_F00D, 1, 32'h1111_2222,
                4'b0010, 1'b0, 32'h1111_2222, 2);

        // Randomized transactions against the reference address map.
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            rd = $urandom;
            dly = $urandom_range(0, 11) - 1;
            sl = ref_slave(a);
            if (sl < 0) begin
                run_txn($sformatf("rnd%0d", n), a, 1'($urandom), 4'($urandom), $urandom, dly, rd,
                        4'b0000, 1'b1, 32'h0, 1);
            end else begin
                es = 4'b0001 << sl;
                if (dly >= 0 && dly < TO)
                    run_txn($sformatf("rnd%0d", n), a, 1'($urandom), 4'($urandom), $urandom, dly, rd,
                            es, 1'b0, rd, dly + 1);
                else
                    run_txn($sformatf("rnd%0d", n), a, 1'($urandom), 4'($urandom), $urandom, dly, rd,
                            es, 1'b1, 32'h0, TO);
            end
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
